// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector session controller.
// Holds the one-hot state encoding, default widths and the length clamp helper.
// Contents: ST_* localparams, state_t, DEF_* widths, LEN_W, clamp_len().
package seq_det_pkg;

  // Default widths for the pattern history, hit counter and idle timer.
  localparam int DEF_PAT_W = 8;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_TMO_W = 16;

  // Width of the pattern length field and of the fill counter.
  localparam int LEN_W = 4;

  // One-hot state encodings.
  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_ARM  = 4'b0010;
  localparam logic [3:0] ST_RUN  = 4'b0100;
  localparam logic [3:0] ST_DONE = 4'b1000;

  typedef enum logic [3:0] {
    S_IDLE = ST_IDLE,
    S_ARM  = ST_ARM,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  // A zero length is treated as one bit; anything longer than the history
  // register is cut down to the history width.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] max_len);
    if (len == '0) begin
      return LEN_W'(1);
    end else if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/seq_shift_match.sv
// Bit history shift register, fill counter and masked pattern compare.
// Latency: o_match_n is combinational for the bit being shifted this cycle.
// Backpressure: none here; the caller only raises i_shift_en on an accepted bit.
// Ports: i_clk/i_rst (sync, active high), i_shift_en/i_bit (shift one bit),
//        i_clr (clear history and fill), i_overlap (0 = restart fill on hit),
//        i_len/i_pattern (active length and pattern), o_match_n (match for
//        the shifted bit), o_hist/o_fill (registered history and fill).
module seq_shift_match
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_shift_en,
  input  logic             i_bit,
  input  logic             i_clr,
  input  logic             i_overlap,
  input  logic [LEN_W-1:0] i_len,
  input  logic [PAT_W-1:0] i_pattern,
  output logic             o_match_n,
  output logic [PAT_W-1:0] o_hist,
  output logic [LEN_W-1:0] o_fill
);

  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;

  logic [PAT_W-1:0] w_hist_n;
  logic [LEN_W-1:0] w_fill_n;
  logic [PAT_W-1:0] w_mask;
  logic             w_match;

  // Newest bit enters at bit 0, so the first pattern bit ends up at [len-1].
  assign w_hist_n = {r_hist[PAT_W-2:0], i_bit};

  // Fill counts valid history bits and stops at the active length.
  assign w_fill_n = (r_fill >= i_len) ? i_len : (r_fill + LEN_W'(1));

  // Only the low len bits of history and pattern take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (LEN_W'(i) < i_len);
    end
  end

  assign w_match   = (w_fill_n == i_len) && (((w_hist_n ^ i_pattern) & w_mask) == '0);
  assign o_match_n = i_shift_en & w_match;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_shift_en) begin
      r_hist <= w_hist_n;
      // Non-overlapping mode needs a full fresh pattern after every hit.
      r_fill <= (w_match && !i_overlap) ? '0 : w_fill_n;
    end
  end

  assign o_hist = r_hist;
  assign o_fill = r_fill;

endmodule

// File: rtl/seq_det_ctrl.sv
// Session controller: latches pattern/config, paces bits in, counts hits.
// Latency: hit_pulse and hit_count update one cycle after the accepting edge.
// Backpressure: o_bit_ready is high only in RUN; bits are taken on valid & ready.
// Ports: i_clk/i_rst (sync, active high); i_cfg_* session configuration,
//        start and abort; i_bit_valid/i_bit_data with o_bit_ready for the bit
//        stream; o_busy, o_hit_pulse, o_hit_count, o_done, o_timed_out status.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TMO_W = DEF_TMO_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_start,
  input  logic             i_cfg_abort,
  input  logic [PAT_W-1:0] i_cfg_pattern,
  input  logic [3:0]       i_cfg_len,
  input  logic             i_cfg_overlap,
  input  logic [CNT_W-1:0] i_cfg_hit_target,
  input  logic [TMO_W-1:0] i_cfg_timeout,
  input  logic             i_bit_valid,
  input  logic             i_bit_data,
  output logic             o_bit_ready,
  output logic             o_busy,
  output logic             o_hit_pulse,
  output logic [CNT_W-1:0] o_hit_count,
  output logic             o_done,
  output logic             o_timed_out
);

  state_t r_state;
  state_t w_state_n;

  // Latched session configuration.
  logic [PAT_W-1:0] r_pattern;
  logic [LEN_W-1:0] r_len;
  logic             r_overlap;
  logic [CNT_W-1:0] r_target;
  logic [TMO_W-1:0] r_timeout;

  logic [CNT_W-1:0] r_hit_count;
  logic             r_hit_pulse;
  logic             r_timed_out;
  logic [TMO_W-1:0] r_tmo_cnt;

  logic             w_latch;
  logic             w_arm;
  logic             w_shift;
  logic             w_match_n;
  logic             w_hit;
  logic             w_tmo_inc;
  logic             w_set_tmo;
  logic [CNT_W-1:0] w_cnt_n;
  logic [TMO_W-1:0] w_tmo_n;
  logic [PAT_W-1:0] w_hist;
  logic [LEN_W-1:0] w_fill;
  logic             w_unused;

  // Abort discards the bit offered in the same cycle, so it never shifts.
  assign w_shift = (r_state == S_RUN) && i_bit_valid && !i_cfg_abort;

  assign w_cnt_n = (&r_hit_count) ? r_hit_count : (r_hit_count + CNT_W'(1));
  assign w_tmo_n = r_tmo_cnt + TMO_W'(1);

  seq_shift_match #(
    .PAT_W(PAT_W)
  ) u_shift_match (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_shift_en (w_shift),
    .i_bit      (i_bit_data),
    .i_clr      (w_arm),
    .i_overlap  (r_overlap),
    .i_len      (r_len),
    .i_pattern  (r_pattern),
    .o_match_n  (w_match_n),
    .o_hist     (w_hist),
    .o_fill     (w_fill)
  );

  // History and fill are only of interest when probing the sub-block.
  assign w_unused = ^{w_hist, w_fill};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_latch   = 1'b0;
    w_arm     = 1'b0;
    w_hit     = 1'b0;
    w_tmo_inc = 1'b0;
    w_set_tmo = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_cfg_start) begin
          w_latch   = 1'b1;
          w_state_n = S_ARM;
        end
      end
      S_ARM: begin
        w_arm     = 1'b1;
        w_state_n = i_cfg_abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (i_cfg_abort) begin
          w_state_n = S_IDLE;
        end else if (i_bit_valid) begin
          if (w_match_n) begin
            w_hit = 1'b1;
            if ((r_target != '0) && (w_cnt_n == r_target)) begin
              w_state_n = S_DONE;
            end
          end
        end else begin
          // An accepted bit clears the idle timer, so timeout and hit never coincide.
          w_tmo_inc = 1'b1;
          if ((r_timeout != '0) && (w_tmo_n == r_timeout)) begin
            w_set_tmo = 1'b1;
            w_state_n = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pattern <= '0;
      r_len     <= LEN_W'(1);
      r_overlap <= 1'b0;
      r_target  <= '0;
      r_timeout <= '0;
    end else if (w_latch) begin
      r_pattern <= i_cfg_pattern;
      r_len     <= clamp_len(i_cfg_len, LEN_W'(PAT_W));
      r_overlap <= i_cfg_overlap;
      r_target  <= i_cfg_hit_target;
      r_timeout <= i_cfg_timeout;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hit_count <= '0;
      r_hit_pulse <= 1'b0;
      r_timed_out <= 1'b0;
      r_tmo_cnt   <= '0;
    end else begin
      r_hit_pulse <= w_hit;
      if (w_arm) begin
        r_hit_count <= '0;
        r_timed_out <= 1'b0;
        r_tmo_cnt   <= '0;
      end else begin
        if (w_hit) begin
          r_hit_count <= w_cnt_n;
        end
        if (w_set_tmo) begin
          r_timed_out <= 1'b1;
        end
        if (w_shift) begin
          r_tmo_cnt <= '0;
        end else if (w_tmo_inc) begin
          r_tmo_cnt <= w_tmo_n;
        end
      end
    end
  end

  assign o_bit_ready = (r_state == S_RUN);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_hit_pulse = r_hit_pulse;
  assign o_hit_count = r_hit_count;
  assign o_timed_out = r_timed_out;

endmodule
